counter4bit_arbiter: RTL and testbench
======================================

COUNTER4BIT_ARBITER -- requirements
Module: counter4bit_arbiter

Interface
REQ-001 Parameter: CNT_W, default 4, width of the shared counter, of lim0/lim1 and of q.
REQ-002 Port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: req0  input  1  requester 0 asks for the counter; held high until done0 or abort.
REQ-005 Port: lim0  input  CNT_W  requester 0 terminal count; sampled only at grant.
REQ-006 Port: req1  input  1  requester 1 request; same rules as req0.
REQ-007 Port: lim1  input  CNT_W  requester 1 terminal count; sampled only at grant.
REQ-008 Port: gnt0  output  1  requester 0 owns the counter.
REQ-009 Port: gnt1  output  1  requester 1 owns the counter.
REQ-010 Port: done0  output  1  one-cycle pulse: requester 0 count completed.
REQ-011 Port: done1  output  1  one-cycle pulse: requester 1 count completed.
REQ-012 Port: q  output  CNT_W  shared counter value.
REQ-013 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE; all outputs SHALL be registered.
REQ-015 In IDLE with at least one req high: pick a winner, assert its gnt, latch its lim into an internal register, set q=0, go to RUN; all on the same edge.
REQ-016 Winner selection: single requester wins outright; if both are high, the requester not served last wins (round-robin pointer).
REQ-017 In RUN with owner req high and q != latched lim: q <= q+1 each cycle.
REQ-018 In RUN with owner req high and q == latched lim: gnt <= 0, owner done <= 1, q holds, pointer <= owner, go to DONE.
REQ-019 DONE lasts exactly one cycle: done <= 0, go to IDLE; a new grant is possible at the earliest on the edge leaving the following IDLE cycle.
REQ-020 gnt SHALL be high for exactly lim+1 cycles; lim=0 gives one RUN cycle with q=0.
REQ-021 Abort: owner req low in RUN causes gnt <= 0 and a direct return to IDLE on the next edge, with no done pulse, q holding its value and pointer <= owner.
REQ-022 gnt0 and gnt1 SHALL never be high together; done0 and done1 SHALL never be high together.
REQ-023 Arithmetic is modulo 2^CNT_W; lim = 2^CNT_W-1 runs the full range without wrapping before done.
REQ-024 lim changes while granted SHALL NOT affect the running count.

Reset
REQ-025 rst high at a clk edge SHALL force: IDLE, gnt0=gnt1=0, done0=done1=0, q=0, busy=0, pointer=1 (requester 0 wins the first tie).
REQ-026 rst SHALL take priority over every transition, including mid-RUN and DONE; no done is emitted for an interrupted count.

Configuration
REQ-027 Macro COUNTER4BIT_ARBITER_FIXED_PRIO_EN defined: requester 0 SHALL always win ties and the pointer SHALL be unused.
REQ-028 Macro COUNTER4BIT_ARBITER_FIXED_PRIO_EN undefined: the round-robin behaviour of REQ-016 applies.

Verification
REQ-029 rst 2 cycles, then req0=1, lim0=3 -> gnt0 high 4 cycles, q=0,1,2,3, then done0 pulse for 1 cycle, busy low on the following cycle.
REQ-030 req0=req1=1 from reset, lim0=2, lim1=1 -> order gnt0 (3 cycles), done0, IDLE, gnt1 (2 cycles), done1, IDLE, then gnt0 again; with the FIXED_PRIO macro, gnt0 is repeated and gnt1 is starved.
REQ-031 req1=1, lim1=0 -> gnt1 high for 1 cycle with q=0, done1 on the next cycle.
REQ-032 req0=1, lim0=15, req0 dropped when q=5 -> gnt0 low on the next edge, no done0, q holds 5, busy low.
REQ-033 rst asserted mid-RUN at q=7 -> next cycle q=0, all grants and dones 0, IDLE; with both req high afterwards, requester 0 is granted first.
REQ-034 lim0=15 with lim0 changed to 2 after grant -> count still reaches 15, done0 once; the bench asserts gnt/done mutual exclusion throughout.

Source files
------------

// File: rtl/counter4bit_arbiter_if.sv
// rtl/counter4bit_arbiter_if.sv - request/limit/grant/count bundle for counter4bit_arbiter
interface counter4bit_arbiter_if #(parameter int CNT_W = 4);
  logic             req0;
  logic [CNT_W-1:0] lim0;
  logic             req1;
  logic [CNT_W-1:0] lim1;
  logic             gnt0;
  logic             gnt1;
  logic             done0;
  logic             done1;
  logic [CNT_W-1:0] q;
  logic             busy;

  modport master (
    output req0, lim0, req1, lim1,
    input  gnt0, gnt1, done0, done1, q, busy
  );

  modport slave (
    input  req0, lim0, req1, lim1,
    output gnt0, gnt1, done0, done1, q, busy
  );
endinterface

// File: rtl/counter4bit_arbiter.sv
// rtl/counter4bit_arbiter.sv - two-requester shared counter with round-robin grant
// Macro COUNTER4BIT_ARBITER_FIXED_PRIO_EN: requester 0 always wins ties, no pointer.
module counter4bit_arbiter #(
  parameter int CNT_W = 4
) (
  input logic                  clk,
  input logic                  rst,
  counter4bit_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_owner, w_owner_nxt;
  logic [CNT_W-1:0] r_lim, w_lim_nxt;
  logic [CNT_W-1:0] r_q, w_q_nxt;
  logic             r_gnt0, w_gnt0_nxt;
  logic             r_gnt1, w_gnt1_nxt;
  logic             r_done0, w_done0_nxt;
  logic             r_done1, w_done1_nxt;
  logic             r_busy;
  logic             w_win;
  logic             w_owner_req;

  assign w_owner_req = r_owner ? bus.req1 : bus.req0;

`ifdef COUNTER4BIT_ARBITER_FIXED_PRIO_EN
  assign w_win = ~bus.req0;
`else
  logic r_ptr;
  logic w_release;

  // w_win = 1 selects requester 1; on a tie the one not served last wins
  assign w_win     = (bus.req0 & bus.req1) ? ~r_ptr : bus.req1;
  assign w_release = (r_state == RUN) & (~w_owner_req | (r_q == r_lim));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= 1'b1;
    end else if (w_release) begin
      r_ptr <= r_owner;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
      r_lim   <= '0;
      r_q     <= '0;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_lim   <= w_lim_nxt;
      r_q     <= w_q_nxt;
      r_gnt0  <= w_gnt0_nxt;
      r_gnt1  <= w_gnt1_nxt;
      r_done0 <= w_done0_nxt;
      r_done1 <= w_done1_nxt;
      r_busy  <= (w_state_nxt != IDLE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_lim_nxt   = r_lim;
    w_q_nxt     = r_q;
    w_gnt0_nxt  = r_gnt0;
    w_gnt1_nxt  = r_gnt1;
    w_done0_nxt = r_done0;
    w_done1_nxt = r_done1;
    case (r_state)
      IDLE: begin
        if (bus.req0 | bus.req1) begin
          w_owner_nxt = w_win;
          w_gnt0_nxt  = ~w_win;
          w_gnt1_nxt  = w_win;
          w_lim_nxt   = w_win ? bus.lim1 : bus.lim0;
          w_q_nxt     = '0;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        // abort takes precedence over reaching the terminal count
        if (!w_owner_req) begin
          w_gnt0_nxt  = 1'b0;
          w_gnt1_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end else if (r_q == r_lim) begin
          w_gnt0_nxt  = 1'b0;
          w_gnt1_nxt  = 1'b0;
          w_done0_nxt = ~r_owner;
          w_done1_nxt = r_owner;
          w_state_nxt = DONE;
        end else begin
          w_q_nxt = r_q + CNT_W'(1);
        end
      end
      DONE: begin
        w_done0_nxt = 1'b0;
        w_done1_nxt = 1'b0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_gnt0_nxt  = 1'b0;
        w_gnt1_nxt  = 1'b0;
        w_done0_nxt = 1'b0;
        w_done1_nxt = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.gnt0  = r_gnt0;
  assign bus.gnt1  = r_gnt1;
  assign bus.done0 = r_done0;
  assign bus.done1 = r_done1;
  assign bus.q     = r_q;
  assign bus.busy  = r_busy;

endmodule

// File: tb/tb_counter4bit_arbiter.sv
// tb/tb_counter4bit_arbiter.sv - self-checking bench for counter4bit_arbiter
module tb_counter4bit_arbiter;
  localparam int CNT_W = 4;
  localparam int MAXV  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  counter4bit_arbiter_if #(.CNT_W(CNT_W)) bus ();

  counter4bit_arbiter #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: who owns the counter (-1 none), who is pulsing done (-1 none),
  // the count, the limit captured at grant and the last requester served.
  int m_own  = -1;
  int m_done = -1;
  int m_q    = 0;
  int m_lim  = 0;
  int m_last = 1;
  bit chk_en = 1'b0;

  always @(posedge clk) begin
    int rq[2];
    int lm[2];
    int win;
    rq[0] = int'(bus.req0);
    rq[1] = int'(bus.req1);
    lm[0] = int'(bus.lim0);
    lm[1] = int'(bus.lim1);
    if (rst) begin
      m_own  = -1;
      m_done = -1;
      m_q    = 0;
      m_last = 1;
      chk_en = 1'b1;
    end else if (m_done >= 0) begin
      m_done = -1;
    end else if (m_own < 0) begin
      if (rq[0] != 0 || rq[1] != 0) begin
        if (rq[0] != 0 && rq[1] != 0) begin
`ifdef COUNTER4BIT_ARBITER_FIXED_PRIO_EN
          win = 0;
`else
          win = 1 - m_last;
`endif
        end else begin
          win = (rq[0] != 0) ? 0 : 1;
        end
        m_own = win;
        m_lim = lm[win];
        m_q   = 0;
      end
    end else if (rq[m_own] == 0) begin
      m_last = m_own;
      m_own  = -1;
    end else if (m_q == m_lim) begin
      m_done = m_own;
      m_last = m_own;
      m_own  = -1;
    end else begin
      m_q = (m_q + 1) % (MAXV + 1);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_gnt0", int'(bus.gnt0), int'(m_own == 0));
      chk("m_gnt1", int'(bus.gnt1), int'(m_own == 1));
      chk("m_done0", int'(bus.done0), int'(m_done == 0));
      chk("m_done1", int'(bus.done1), int'(m_done == 1));
      chk("m_q", int'(bus.q), m_q);
      chk("m_busy", int'(bus.busy), int'(m_own >= 0 || m_done >= 0));
      chk("gnt_mutex", int'(bus.gnt0 & bus.gnt1), 0);
      chk("done_mutex", int'(bus.done0 & bus.done1), 0);
    end
  end

  function automatic int trace();
    return int'(bus.gnt0) + 2 * int'(bus.gnt1) + 4 * int'(bus.done0) + 8 * int'(bus.done1);
  endfunction

`ifdef COUNTER4BIT_ARBITER_FIXED_PRIO_EN
  int exp_tie[10] = '{1, 1, 1, 4, 0, 1, 1, 1, 4, 0};
`else
  int exp_tie[10] = '{1, 1, 1, 4, 0, 2, 2, 8, 0, 1};
`endif

  initial begin
    int gcnt;
    int dcnt;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.lim0 = '0;
    bus.lim1 = '0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_gnt0", int'(bus.gnt0), 0);
    chk("rst_q", int'(bus.q), 0);

    // single requester, lim 3
    rst = 1'b0;
    bus.req0 = 1'b1;
    bus.lim0 = CNT_W'(3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t1_gnt0", int'(bus.gnt0), 1);
      chk("t1_q", int'(bus.q), i);
    end
    @(negedge clk);
    chk("t1_done0", int'(bus.done0), 1);
    chk("t1_gnt0_off", int'(bus.gnt0), 0);
    bus.req0 = 1'b0;
    @(negedge clk);
    chk("t1_done0_off", int'(bus.done0), 0);
    chk("t1_busy_off", int'(bus.busy), 0);

    // lim 0 on requester 1
    bus.req1 = 1'b1;
    bus.lim1 = '0;
    @(negedge clk);
    chk("t2_gnt1", int'(bus.gnt1), 1);
    chk("t2_q", int'(bus.q), 0);
    @(negedge clk);
    chk("t2_done1", int'(bus.done1), 1);
    bus.req1 = 1'b0;
    @(negedge clk);
    chk("t2_busy", int'(bus.busy), 0);

    // tie from reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    bus.lim0 = CNT_W'(2);
    bus.lim1 = CNT_W'(1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t3_trace", trace(), exp_tie[i]);
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("t3_idle", int'(bus.busy), 0);

    // abort at q=5
    bus.req0 = 1'b1;
    bus.lim0 = CNT_W'(15);
    repeat (6) @(negedge clk);
    chk("t4_q5", int'(bus.q), 5);
    bus.req0 = 1'b0;
    @(negedge clk);
    chk("t4_gnt0", int'(bus.gnt0), 0);
    chk("t4_done0", int'(bus.done0), 0);
    chk("t4_qhold", int'(bus.q), 5);
    chk("t4_busy", int'(bus.busy), 0);

    // reset mid-run at q=7, then tie goes to requester 0
    bus.req0 = 1'b1;
    bus.lim0 = CNT_W'(15);
    repeat (8) @(negedge clk);
    chk("t5_q7", int'(bus.q), 7);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_q", int'(bus.q), 0);
    chk("t5_gnt", int'(bus.gnt0 | bus.gnt1), 0);
    chk("t5_done", int'(bus.done0 | bus.done1), 0);
    chk("t5_busy", int'(bus.busy), 0);
    rst = 1'b0;
    bus.req1 = 1'b1;
    bus.lim0 = CNT_W'(1);
    bus.lim1 = CNT_W'(1);
    @(negedge clk);
    chk("t5_first_gnt0", int'(bus.gnt0), 1);
    chk("t5_first_gnt1", int'(bus.gnt1), 0);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (3) @(negedge clk);

    // lim change after grant is ignored
    bus.req0 = 1'b1;
    bus.lim0 = CNT_W'(15);
    gcnt = 0;
    dcnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      gcnt += int'(bus.gnt0);
      dcnt += int'(bus.done0);
      if (i == 0) bus.lim0 = CNT_W'(2);
      if (bus.done0) bus.req0 = 1'b0;
    end
    chk("t6_gnt_cycles", gcnt, 16);
    chk("t6_done_count", dcnt, 1);

    // random traffic against the reference
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(99) == 0);
      if (bus.req0) begin
        if ($urandom_range(19) == 0) bus.req0 = 1'b0;
      end else if ($urandom_range(3) == 0) begin
        bus.req0 = 1'b1;
      end
      if (bus.req1) begin
        if ($urandom_range(19) == 0) bus.req1 = 1'b0;
      end else if ($urandom_range(3) == 0) begin
        bus.req1 = 1'b1;
      end
      bus.lim0 = ($urandom_range(3) == 0) ? CNT_W'($urandom_range(MAXV)) : CNT_W'($urandom_range(3));
      bus.lim1 = ($urandom_range(3) == 0) ? CNT_W'($urandom_range(MAXV)) : CNT_W'($urandom_range(3));
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
